// File: rtl/game_pkg.sv
// Shared Breakout geometry and game-state encoding used by the bar controller,
// the renderer and the ball event generator.
package game_pkg;

    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int BALL_SIZE = 8;
    localparam int BAR_W     = 64;
    localparam int BAR_Y     = 460;
    localparam int STEP      = 2;
    localparam int CW        = 10;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } game_state_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a synchronous level: one flop holding the previous
// level, with the edge reported in the same cycle the level goes high.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_reg <= 1'b0;
        end else begin
            level_reg <= level;
        end
    end

    assign rise = level & ~level_reg;

endmodule

// File: rtl/ball_event_gen.sv
// Breakout ball motion and game events: moves the ball once per frame, bounces it
// off the walls and the bar, flags bar hits for the score counter and detects misses.
module ball_event_gen
    import game_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          frame_tick,
    input  logic          launch,
    input  logic [CW-1:0] bar_x,
    output logic [CW-1:0] ball_x,
    output logic [CW-1:0] ball_y,
    output logic          hit_bar,
    output logic          start,
    output logic          playing
);

    localparam logic [CW-1:0]        SERVE_X_OFS = CW'((BAR_W - BALL_SIZE) / 2);
    localparam logic [CW-1:0]        SERVE_Y     = CW'(BAR_Y - BALL_SIZE);
    localparam logic signed [CW:0]   STEP_S      = (CW+1)'(STEP);
    localparam logic signed [CW:0]   X_MAX_S     = (CW+1)'(H_RES - BALL_SIZE);
    localparam logic signed [CW:0]   BALL_S      = (CW+1)'(BALL_SIZE);
    localparam logic signed [CW:0]   BAR_Y_S     = (CW+1)'(BAR_Y);
    localparam logic signed [CW:0]   V_RES_S     = (CW+1)'(V_RES);
    localparam logic [CW:0]          BALL_U      = (CW+1)'(BALL_SIZE);
    localparam logic [CW:0]          BAR_W_U     = (CW+1)'(BAR_W);

    game_state_t state_reg;
    logic        dx_reg;   // 1: moving right
    logic        dy_reg;   // 1: moving down
    logic        launch_rise;

    logic signed [CW:0] x_s;
    logic signed [CW:0] y_s;
    logic signed [CW:0] nx;
    logic signed [CW:0] ny;
    logic               overlap;
    logic               x_low;
    logic               x_high;
    logic               top_hit;
    logic               bar_hit;
    logic               miss;

    rise_detect u_launch_rise (
        .clock (clock),
        .reset (reset),
        .level (launch),
        .rise  (launch_rise)
    );

    // Candidate position and collision flags; bar overlap uses the pre-move x.
    always_comb begin
        x_s     = signed'({1'b0, ball_x});
        y_s     = signed'({1'b0, ball_y});
        nx      = dx_reg ? (x_s + STEP_S) : (x_s - STEP_S);
        ny      = dy_reg ? (y_s + STEP_S) : (y_s - STEP_S);
        overlap = (({1'b0, ball_x} + BALL_U) > {1'b0, bar_x}) &&
                  ({1'b0, ball_x} < ({1'b0, bar_x} + BAR_W_U));
        x_low   = nx[CW];
        x_high  = !nx[CW] && (nx > X_MAX_S);
        top_hit = ny[CW] || (ny == '0);
        bar_hit = dy_reg && ((ny + BALL_S) >= BAR_Y_S) && overlap;
        miss    = dy_reg && !overlap && ((ny + BALL_S) >= V_RES_S);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= SERVE;
            ball_x    <= SERVE_X_OFS;
            ball_y    <= SERVE_Y;
            dx_reg    <= 1'b1;
            dy_reg    <= 1'b0;
            hit_bar   <= 1'b0;
            start     <= 1'b1;
            playing   <= 1'b0;
        end else begin
            // hit_bar lives for exactly one frame; a new bounce below re-arms it.
            if (frame_tick) begin
                hit_bar <= 1'b0;
            end
            case (state_reg)
                SERVE: begin
                    if (frame_tick) begin
                        ball_x <= bar_x + SERVE_X_OFS;
                        ball_y <= SERVE_Y;
                    end
                    if (launch_rise) begin
                        state_reg <= PLAY;
                        dx_reg    <= 1'b1;
                        dy_reg    <= 1'b0;
                        start     <= 1'b0;
                        playing   <= 1'b1;
                    end
                end
                PLAY: begin
                    if (frame_tick) begin
                        if (miss) begin
                            state_reg <= OVER;
                            playing   <= 1'b0;
                        end else begin
                            if (x_low) begin
                                ball_x <= '0;
                                dx_reg <= 1'b1;
                            end else if (x_high) begin
                                ball_x <= X_MAX_S[CW-1:0];
                                dx_reg <= 1'b0;
                            end else begin
                                ball_x <= nx[CW-1:0];
                            end
                            if (top_hit) begin
                                ball_y <= '0;
                                dy_reg <= 1'b1;
                            end else if (bar_hit) begin
                                ball_y  <= SERVE_Y;
                                dy_reg  <= 1'b0;
                                hit_bar <= 1'b1;
                            end else begin
                                ball_y <= ny[CW-1:0];
                            end
                        end
                    end
                end
                OVER: begin
                    if (launch_rise) begin
                        state_reg <= SERVE;
                        start     <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= SERVE;
                    start     <= 1'b1;
                    playing   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_event_gen.sv
// Directed bench for ball_event_gen: an integer game model checked every cycle,
// plus hand-computed literal positions at the key bounce, miss and reset points.
module tb_ball_event_gen;

    localparam int M_SERVE = 0;
    localparam int M_PLAY  = 1;
    localparam int M_OVER  = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       launch = 1'b0;
    logic [9:0] bar_x = 10'd100;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       hit_bar;
    logic       start;
    logic       playing;

    int tests_run    = 0;
    int tests_failed = 0;
    int hit_count    = 0;
    bit check_en     = 1'b0;

    // behavioural model state
    int m_state = M_SERVE;
    int mx = 28;
    int my = 452;
    int mdx = 1;
    int mdy = -1;
    int mhit = 0;
    int mprev = 0;

    ball_event_gen dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .launch     (launch),
        .bar_x      (bar_x),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .hit_bar    (hit_bar),
        .start      (start),
        .playing    (playing)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One game step straight from the rules: integer positions, signed directions.
    task automatic model_step();
        int  nx;
        int  ny;
        bit  rise;
        bit  ovl;
        if (reset) begin
            m_state = M_SERVE; mx = 28; my = 452; mdx = 1; mdy = -1; mhit = 0; mprev = 0;
            return;
        end
        rise  = launch && (mprev == 0);
        mprev = launch ? 1 : 0;
        if (frame_tick) mhit = 0;
        case (m_state)
            M_SERVE: begin
                if (frame_tick) begin
                    mx = int'(bar_x) + 28;
                    my = 452;
                end
                if (rise) begin
                    m_state = M_PLAY; mdx = 1; mdy = -1;
                end
            end
            M_PLAY: begin
                if (frame_tick) begin
                    nx  = mx + 2 * mdx;
                    ny  = my + 2 * mdy;
                    ovl = (mx + 8 > int'(bar_x)) && (mx < int'(bar_x) + 64);
                    if (mdy > 0 && !ovl && ny + 8 >= 480) begin
                        m_state = M_OVER;
                    end else begin
                        if (nx < 0) begin mx = 0; mdx = 1; end
                        else if (nx > 632) begin mx = 632; mdx = -1; end
                        else mx = nx;
                        if (ny <= 0) begin my = 0; mdy = 1; end
                        else if (mdy > 0 && ny + 8 >= 460 && ovl) begin
                            my = 452; mdy = -1; mhit = 1;
                        end else my = ny;
                    end
                end
            end
            default: begin
                if (rise) m_state = M_SERVE;
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            model_step();
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    initial begin
        bit prev_hit;
        prev_hit = 1'b0;
        forever begin
            @(negedge clock);
            if (check_en) begin
                check("model ball_x",  int'(ball_x),  mx);
                check("model ball_y",  int'(ball_y),  my);
                check("model hit_bar", int'(hit_bar), mhit);
                check("model start",   int'(start),   (m_state == M_SERVE) ? 1 : 0);
                check("model playing", int'(playing), (m_state == M_PLAY) ? 1 : 0);
                if (hit_bar && !prev_hit) hit_count++;
                prev_hit = hit_bar;
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            cyc();
            cyc();
        end
    endtask

    task automatic press();
        launch = 1'b1;
        cyc();
        launch = 1'b0;
        cyc();
    endtask

    task automatic pin(input string tag, input int x, input int y, input int hb,
                       input int st, input int pl);
        check({tag, " ball_x"},  int'(ball_x),  x);
        check({tag, " ball_y"},  int'(ball_y),  y);
        check({tag, " hit_bar"}, int'(hit_bar), hb);
        check({tag, " start"},   int'(start),   st);
        check({tag, " playing"}, int'(playing), pl);
    endtask

    initial begin
        #2 reset = 1'b1;
        cyc();
        cyc();
        pin("in reset", 28, 452, 0, 1, 0);
        reset = 1'b0;
        check_en = 1'b1;
        cyc();

        // serve follows the bar
        frames(3);
        pin("serve bar100", 128, 452, 0, 1, 0);

        // launch, rise to the top wall
        press();
        check("launch playing", int'(playing), 1);
        bar_x = 10'd200;
        frames(226);
        pin("top wall", 580, 0, 0, 0, 1);
        frames(27);
        pin("right clamp", 632, 54, 0, 0, 1);
        frames(199);
        pin("bar bounce", 234, 452, 1, 0, 1);
        check("hit count 1", hit_count, 1);
        frames(1);
        pin("after bounce", 232, 450, 0, 0, 1);
        frames(117);
        pin("left wall", 0, 216, 0, 0, 1);
        bar_x = 10'd0;
        frames(1);
        pin("left rebound", 2, 214, 0, 0, 1);

        // miss with the bar far away
        frames(343);
        pin("miss over", 580, 470, 0, 0, 0);
        check("hit count after miss", hit_count, 1);
        frames(2);
        pin("over frozen", 580, 470, 0, 0, 0);
        press();
        check("over to serve start", int'(start), 1);
        frames(1);
        pin("reserve", 28, 452, 0, 1, 0);

        // top-right corner, then a bar hit interrupted by reset
        bar_x = 10'd154;
        frames(1);
        press();
        frames(225);
        pin("pre corner", 632, 2, 0, 0, 1);
        frames(1);
        pin("corner", 632, 0, 0, 0, 1);
        frames(1);
        pin("corner rebound", 630, 2, 0, 0, 1);
        frames(225);
        pin("second bounce", 180, 452, 1, 0, 1);
        check("hit count 2", hit_count, 2);
        #1 reset = 1'b1;
        #1;
        pin("async reset", 28, 452, 0, 1, 0);
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        pin("post reset", 28, 452, 0, 1, 0);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
